pb_gpio_banked: RTL



---
 rtl/pb_gpio_banked.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pb_gpio_banked.sv
// Banked Picoblaze GPIO with edge-detect interrupts and write-1-to-clear status.
// Optional PB_GPIO_SYNC_EN adds a 2-flop synchroniser ahead of the pin sample register.
module pb_gpio_banked #(
  parameter int          GPIO_WIDTH        = 8,
  parameter logic [7:0]  GPIO_BASE_ADDRESS = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire [GPIO_WIDTH-1:0]  gpio,
  input  logic [7:0]            port_id,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic                  read_strobe,
  input  logic                  write_strobe,
  output logic                  interrupt
);
  localparam int NB = (GPIO_WIDTH + 7) / 8;
  localparam int PW = NB * 8;

  logic [GPIO_WIDTH-1:0] out_q, oen_q, ien_q, istat_q, edge_q, both_q, s_q;
  logic [GPIO_WIDTH-1:0] out_d, oen_d, ien_d, istat_d, edge_d, both_d, s_d;
  logic [GPIO_WIDTH-1:0] pin, rise, fall, evt, w1c;
  logic [PW-1:0]         out_p, oen_p, in_p, ien_p, istat_p, edge_p, both_p;
  logic [7:0]            data_out_q, data_out_d, rd;
  logic                  irq_q, irq_d;
  logic [7:0]            off;
  logic [4:0]            bank;
  logic [2:0]            rsel;
  logic                  hit, wr_en;
  logic                  unused_rd_strobe;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
    assign gpio[i] = oen_q[i] ? out_q[i] : 1'bz;
  end
  assign pin = gpio;

  assign off   = port_id - GPIO_BASE_ADDRESS;
  assign bank  = off[7:3];
  assign rsel  = off[2:0];
  assign hit   = int'(bank) < NB;
  assign wr_en = write_strobe && hit;
  assign unused_rd_strobe = read_strobe;

`ifdef PB_GPIO_SYNC_EN
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  logic [1:0]            prime_q;
  // s holds its reset-time pin sample until the cleared synchroniser has refilled
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end
  assign s_d = prime_q[1] ? sync2_q : s_q;
`else
  assign s_d = pin;
`endif

  assign rise = s_d & ~s_q;
  assign fall = ~s_d & s_q;
  assign evt  = (both_q & (rise | fall)) | (~both_q & ((edge_q & rise) | (~edge_q & fall)));

  always_comb begin
    out_d  = out_q;
    oen_d  = oen_q;
    ien_d  = ien_q;
    edge_d = edge_q;
    both_d = both_q;
    w1c    = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (wr_en && int'(bank) == i / 8) begin
        case (rsel)
          3'd0: out_d[i]  = data_in[3'(i)];
          3'd1: oen_d[i]  = data_in[3'(i)];
          3'd3: ien_d[i]  = data_in[3'(i)];
          3'd4: w1c[i]    = data_in[3'(i)];
          3'd5: edge_d[i] = data_in[3'(i)];
          3'd6: both_d[i] = data_in[3'(i)];
          default: ;
        endcase
      end
    end
  end

  assign istat_d = evt | (istat_q & ~w1c);
  assign irq_d   = |(istat_q & ien_q);

  assign out_p   = PW'(out_q);
  assign oen_p   = PW'(oen_q);
  assign in_p    = PW'(s_q);
  assign ien_p   = PW'(ien_q);
  assign istat_p = PW'(istat_q);
  assign edge_p  = PW'(edge_q);
  assign both_p  = PW'(both_q);

  always_comb begin
    rd = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (int'(bank) == b) begin
        case (rsel)
          3'd0: rd = out_p[b*8 +: 8];
          3'd1: rd = oen_p[b*8 +: 8];
          3'd2: rd = in_p[b*8 +: 8];
          3'd3: rd = ien_p[b*8 +: 8];
          3'd4: rd = istat_p[b*8 +: 8];
          3'd5: rd = edge_p[b*8 +: 8];
          3'd6: rd = both_p[b*8 +: 8];
          default: rd = 8'h00;
        endcase
      end
    end
    data_out_d = hit ? rd : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q      <= '0;
      oen_q      <= '0;
      ien_q      <= '0;
      istat_q    <= '0;
      edge_q     <= '1;
      both_q     <= '0;
      s_q        <= pin;
      data_out_q <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oen_q      <= oen_d;
      ien_q      <= ien_d;
      istat_q    <= istat_d;
      edge_q     <= edge_d;
      both_q     <= both_d;
      s_q        <= s_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out  = data_out_q;
  assign interrupt = irq_q;
endmodule
